block_responder: RTL and testbench

//   Core-side end of the block dispatch handshake: one instance per compute core.

---
 rtl/block_responder.sv | 152 +++++++++++++++
 tb/tb_block_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/block_responder.sv
`timescale 1ns/1ps
// block_responder: core-side end of the block dispatch handshake.
// Latches block metadata, enables threads, runs the scheduler, drains LSU traffic.
module block_responder #(
    parameter  int THREADS_PER_BLOCK = 4,
    localparam int CW = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         block_reset,
    input  logic                         block_start,
    input  logic [7:0]                   block_id,
    input  logic [CW-1:0]                block_thread_count,
    output logic                         block_done,
    output logic                         sched_start,
    output logic [7:0]                   sched_block_id,
    input  logic                         sched_done,
    output logic [THREADS_PER_BLOCK-1:0] thread_enable,
    input  logic [THREADS_PER_BLOCK-1:0] lsu_busy,
    output logic [15:0]                  cycle_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [7:0]                     id_q, id_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [THREADS_PER_BLOCK-1:0]   te_q, te_d;
    logic [7:0]                     sbid_q, sbid_d;
    logic                           start_q, start_d;
    logic                           done_q, done_d;
    logic [15:0]                    cyc_q, cyc_d;
    logic [THREADS_PER_BLOCK-1:0]   mask;
    logic                           busy;

    // Thread mask from latched count; counts above the core width enable every thread.
    always_comb begin
        mask = '0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (CW'(i) < cnt_q) begin
                mask[i] = 1'b1;
            end
        end
    end

    assign busy = |(lsu_busy & te_q);

    // Next-state and datapath updates; block_reset overrides everything.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        te_d    = te_q;
        sbid_d  = sbid_q;
        start_d = start_q;
        done_d  = done_q;
        cyc_d   = cyc_q;

        if (state_q == LOAD || state_q == RUN || state_q == DRAIN) begin
            if (cyc_q != 16'hFFFF) begin
                cyc_d = cyc_q + 16'd1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (block_start) begin
                    id_d  = block_id;
                    cnt_d = block_thread_count;
                    cyc_d = '0;
                    if (block_thread_count == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                te_d    = mask;
                sbid_d  = id_q;
                start_d = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (sched_done) begin
                    start_d = 1'b0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!busy) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (block_reset) begin
            state_d = IDLE;
            id_d    = '0;
            cnt_d   = '0;
            te_d    = '0;
            sbid_d  = '0;
            start_d = 1'b0;
            done_d  = 1'b0;
            cyc_d   = '0;
        end
    end

    // State and datapath registers with asynchronous global reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            id_q    <= '0;
            cnt_q   <= '0;
            te_q    <= '0;
            sbid_q  <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            te_q    <= te_d;
            sbid_q  <= sbid_d;
            start_q <= start_d;
            done_q  <= done_d;
            cyc_q   <= cyc_d;
        end
    end

    assign block_done     = done_q;
    assign sched_start    = start_q;
    assign sched_block_id = sbid_q;
    assign thread_enable  = te_q;
    assign cycle_count    = cyc_q;

endmodule

// File: tb/tb_block_responder.sv
`timescale 1ns/1ps
// tb_block_responder: directed dispatch scenarios with a completion scoreboard.
// Stimulus pushes expected block results; a negedge monitor checks each block_done rise.
module tb_block_responder;

    localparam int TPB = 4;
    localparam int CW  = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           block_reset = 1'b0;
    logic           block_start = 1'b0;
    logic [7:0]     block_id = '0;
    logic [CW-1:0]  block_thread_count = '0;
    logic           block_done;
    logic           sched_start;
    logic [7:0]     sched_block_id;
    logic           sched_done = 1'b0;
    logic [TPB-1:0] thread_enable;
    logic [TPB-1:0] lsu_busy = '0;
    logic [15:0]    cycle_count;

    typedef struct {
        logic [3:0]  te;
        logic [7:0]  id;
        logic [15:0] cc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   seen = 0;
    logic ss_seen = 1'b0;
    logic prev_done = 1'b0;

    block_responder #(.THREADS_PER_BLOCK(TPB)) dut (
        .clk(clk),
        .reset(reset),
        .block_reset(block_reset),
        .block_start(block_start),
        .block_id(block_id),
        .block_thread_count(block_thread_count),
        .block_done(block_done),
        .sched_start(sched_start),
        .sched_block_id(sched_block_id),
        .sched_done(sched_done),
        .thread_enable(thread_enable),
        .lsu_busy(lsu_busy),
        .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_blk(input logic [3:0] te, input logic [7:0] id,
                              input logic [15:0] cc);
        exp_t e;
        e.te = te;
        e.id = id;
        e.cc = cc;
        q.push_back(e);
    endtask

    // Accept, load, run for runc cycles, pulse sched_done; leaves DUT in DRAIN.
    task automatic run_block(input logic [7:0] id, input logic [CW-1:0] n,
                             input int runc, input logic [3:0] busy,
                             input logic [3:0] te);
        block_start = 1'b1;
        block_id = id;
        block_thread_count = n;
        tick;
        tick;
        check("run_sched_start", 32'(sched_start), 32'd1);
        check("run_thread_enable", 32'(thread_enable), 32'(te));
        check("run_sched_block_id", 32'(sched_block_id), 32'(id));
        repeat (runc - 1) tick;
        sched_done = 1'b1;
        lsu_busy = busy;
        tick;
        sched_done = 1'b0;
        check("drain_sched_start", 32'(sched_start), 32'd0);
    endtask

    task automatic soft_reset;
        block_start = 1'b0;
        block_reset = 1'b1;
        tick;
        block_reset = 1'b0;
        check("soft_reset_done", 32'(block_done), 32'd0);
        check("soft_reset_te", 32'(thread_enable), 32'd0);
    endtask

    // Scoreboard monitor: compare each rising block_done against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (sched_start) ss_seen = 1'b1;
            if (block_done && !prev_done) begin
                if (q.size() == 0) begin
                    check("sb_unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    seen++;
                    check("sb_thread_enable", 32'(thread_enable), 32'(e.te));
                    check("sb_sched_block_id", 32'(sched_block_id), 32'(e.id));
                    check("sb_cycle_count", 32'(cycle_count), 32'(e.cc));
                end
            end
            prev_done = block_done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick;
        reset = 1'b0;
        tick;
        check("rst_block_done", 32'(block_done), 32'd0);
        check("rst_sched_start", 32'(sched_start), 32'd0);
        check("rst_sched_block_id", 32'(sched_block_id), 32'd0);
        check("rst_thread_enable", 32'(thread_enable), 32'd0);
        check("rst_cycle_count", 32'(cycle_count), 32'd0);

        // T1: full block, 10 run cycles, 1 drain cycle
        expect_blk(4'b1111, 8'd3, 16'd12);
        run_block(8'd3, 3'd4, 10, 4'b0000, 4'b1111);
        tick;
        check("t1_done", 32'(block_done), 32'd1);
        block_start = 1'b0;
        repeat (3) tick;
        check("t1_done_held", 32'(block_done), 32'd1);
        check("t1_cc_frozen", 32'(cycle_count), 32'd12);
        soft_reset;

        // T2: partial block, busy bits on disabled threads ignored
        expect_blk(4'b0011, 8'd4, 16'd5);
        run_block(8'd4, 3'd2, 3, 4'b1100, 4'b0011);
        tick;
        check("t2_done", 32'(block_done), 32'd1);
        lsu_busy = '0;
        soft_reset;

        // T3: drain waits for enabled thread LSU traffic
        expect_blk(4'b0111, 8'd5, 16'd9);
        run_block(8'd5, 3'd3, 2, 4'b0001, 4'b0111);
        repeat (5) tick;
        check("t3_busy_not_done", 32'(block_done), 32'd0);
        lsu_busy = '0;
        tick;
        check("t3_done_after_clear", 32'(block_done), 32'd1);
        soft_reset;

        // T4: zero-thread block completes immediately
        ss_seen = 1'b0;
        expect_blk(4'b0000, 8'd0, 16'd0);
        block_start = 1'b1;
        block_id = 8'd9;
        block_thread_count = 3'd0;
        tick;
        check("t4_done", 32'(block_done), 32'd1);
        check("t4_te", 32'(thread_enable), 32'd0);
        check("t4_cc", 32'(cycle_count), 32'd0);
        repeat (2) tick;
        check("t4_no_sched_start", 32'(ss_seen), 32'd0);
        soft_reset;

        // T5: abort mid-RUN, then restart
        block_start = 1'b1;
        block_id = 8'd2;
        block_thread_count = 3'd4;
        repeat (4) tick;
        check("t5_running", 32'(sched_start), 32'd1);
        block_start = 1'b0;
        block_reset = 1'b1;
        tick;
        block_reset = 1'b0;
        check("t5_abort_start", 32'(sched_start), 32'd0);
        check("t5_abort_te", 32'(thread_enable), 32'd0);
        check("t5_abort_sbid", 32'(sched_block_id), 32'd0);
        check("t5_abort_cc", 32'(cycle_count), 32'd0);
        check("t5_abort_done", 32'(block_done), 32'd0);
        tick;
        expect_blk(4'b0001, 8'd7, 16'd3);
        run_block(8'd7, 3'd1, 1, 4'b0000, 4'b0001);
        tick;
        check("t5_done", 32'(block_done), 32'd1);
        block_id = 8'd8;
        block_thread_count = 3'd4;
        repeat (3) tick;
        check("t5_no_reaccept_sbid", 32'(sched_block_id), 32'd7);
        check("t5_no_reaccept_cc", 32'(cycle_count), 32'd3);

        // T6: back-to-back dispatch loop, including clamped count
        soft_reset;
        expect_blk(4'b1111, 8'd10, 16'd4);
        run_block(8'd10, 3'd4, 2, 4'b0000, 4'b1111);
        tick;
        check("t6_b0_done", 32'(block_done), 32'd1);
        soft_reset;
        expect_blk(4'b1111, 8'd11, 16'd3);
        run_block(8'd11, 3'd7, 1, 4'b0000, 4'b1111);
        tick;
        check("t6_b1_done", 32'(block_done), 32'd1);
        soft_reset;
        expect_blk(4'b0011, 8'd12, 16'd6);
        run_block(8'd12, 3'd2, 4, 4'b0000, 4'b0011);
        tick;
        check("t6_b2_done", 32'(block_done), 32'd1);
        soft_reset;

        // Async reset mid-DRAIN clears without a clock edge
        run_block(8'd13, 3'd4, 1, 4'b1111, 4'b1111);
        check("t6_in_drain_cc", 32'(cycle_count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("async_done", 32'(block_done), 32'd0);
        check("async_te", 32'(thread_enable), 32'd0);
        check("async_sbid", 32'(sched_block_id), 32'd0);
        check("async_cc", 32'(cycle_count), 32'd0);
        lsu_busy = '0;
        block_start = 1'b0;
        tick;
        reset = 1'b0;
        repeat (2) tick;
        check("sb_all_seen", 32'(seen), 32'd8);
        check("sb_queue_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
